sqrt_chain_seq: RTL and testbench
=================================

// Module: sqrt_chain_seq
// PURPOSE
//  Sequencer for the BCD -> binary -> square-root -> BCD conversion chain.
//  Captures the 8-digit BCD operand, checks that every digit is valid, then issues
//  one-cycle start pulses to each stage in turn and waits for each stage's ok.
//  Enforces a per-stage timeout and holds the last good result for the display mux.
//  Sits between the two BCD entry counters and the DEC8_to_BIN27/TASK15_BL/BIN27_to_DEC8 stages.
// PARAMETERS
//  TMO      1023  max cycles waited for ok_bin/ok_sqrt before abort (10-bit counter)
//  DEC_CYC  40    fixed cycles from st_dec to dec_in valid (decoder has no ok)
// PORTS
//  clk      in   1   system clock
//  rst      in   1   asynchronous reset, active-high
//  ce       in   1   trigger tick (ce1ms); conversion starts only on ce
//  force    in   1   level; when 1, every ce starts a run even if X_in is unchanged
//  X_in     in   32  8-digit BCD operand from the entry counters
//  X_cap    out  32  captured operand, drives DEC input of the BCD->binary stage
//  st_bin   out  1   1-cycle start to the BCD->binary stage
//  ok_bin   in   1   BCD->binary done pulse
//  st_sqrt  out  1   1-cycle start to the sqrt stage
//  ok_sqrt  in   1   sqrt done pulse
//  st_dec   out  1   1-cycle start to the binary->BCD stage
//  dec_in   in   32  BCD result from the binary->BCD stage
//  Y        out  32  last good result (BCD)
//  busy     out  1   1 in any state except IDLE
//  done     out  1   1-cycle pulse when Y updates
//  err      out  2   sticky cause of last abort: 00 none, 01 bad BCD, 10 bin timeout, 11 sqrt timeout
// BEHAVIOUR
//  Reset (async): state=IDLE; X_cap, Y = 0; prev operand = 0; all st_* = 0; busy, done = 0; err = 00.
//  States: IDLE, CHK, BIN, SQRT, DEC, FIN.
//  IDLE: on ce=1 and (X_in != prev or force=1): X_cap<=X_in, prev<=X_in, go CHK. Otherwise stay.
//   ce while not IDLE is ignored (no queueing).
//  CHK (1 cycle): any nibble of X_cap > 9 -> err<=01, go IDLE, Y unchanged. Else st_bin=1
//   during the transition cycle into BIN; timer cleared.
//  BIN: wait ok_bin; on ok_bin: st_sqrt pulsed next cycle, go SQRT. timer reaching TMO
//   without ok -> err<=10, IDLE.
//  SQRT: same with ok_sqrt / err 11; on ok_sqrt: st_dec pulsed, go DEC.
//  DEC: count DEC_CYC cycles after st_dec, then go FIN.
//  FIN (1 cycle): Y<=dec_in, done=1, err<=00, go IDLE.
//  ok_bin/ok_sqrt arriving in any other state are ignored; an ok in the same cycle the
//   timer hits TMO counts as success (ok has priority).
//  st_* are registered, exactly one cycle wide, never two asserted together.
//  X_cap held stable from CHK until return to IDLE, so input edits mid-run don't disturb
//   the stages; the edited value is picked up on the first ce after IDLE.
//  Latency (no stall): ce -> st_bin 2 cycles; ok_sqrt -> st_dec 1; st_dec -> done DEC_CYC+1.
//  Timer: 10-bit, saturating; cleared on every stage entry.
// TESTING
//  1. X_in=0x00000144, ce pulse, model ok_bin after 30, ok_sqrt after 20, dec_in=0x12 -> st pulses in order, done once, Y=0x00000012, err=00.
//  2. Same X_in, second ce with force=0 -> stays IDLE, no st_bin; force=1 -> full rerun, done pulses.
//  3. X_in=0x000001A4 (digit A), ce -> err=01 after CHK, no st_bin, Y keeps prior value, busy low next cycle.
//  4. ok_sqrt withheld -> after TMO=1023 cycles in SQRT err=11, IDLE, Y unchanged; next good run clears err to 00.
//  5. ok_bin on exact TMO cycle -> success path, no error; spurious ok_sqrt in IDLE -> no effect.
//  6. rst asserted mid-SQRT -> immediately IDLE, Y=0, busy=0, st_* low; ce after release starts fresh run.

Source files
------------

// File: rtl/sqrt_chain_seq.sv
// Sequencer for the BCD->binary->sqrt->BCD chain: validates the captured operand, pulses each stage start
// in turn and holds the last good result. ce->st_bin 2 cycles, st_dec->done DEC_CYC+1; ce ignored while busy.
module sqrt_chain_seq #(
   parameter int TMO     = 1023,
   parameter int DEC_CYC = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        force_run,
   input  logic [31:0] X_in,
   output logic [31:0] X_cap,
   output logic        st_bin,
   input  logic        ok_bin,
   output logic        st_sqrt,
   input  logic        ok_sqrt,
   output logic        st_dec,
   input  logic [31:0] dec_in,
   output logic [31:0] Y,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err
);

   typedef enum logic [2:0] {S_IDLE, S_CHK, S_BIN, S_SQRT, S_DEC, S_FIN} state_t;

   localparam logic [9:0] TMO_V    = 10'(TMO);
   localparam logic [9:0] DEC_LAST = 10'(DEC_CYC - 1);
   localparam logic [9:0] TMR_MAX  = 10'h3FF;

   state_t      state_q, state_d;
   logic [9:0]  timer_q, timer_d;
   logic [31:0] x_cap_q, x_cap_d;
   logic [31:0] prev_q, prev_d;
   logic [31:0] y_q, y_d;
   logic [1:0]  err_q, err_d;
   logic        st_bin_q, st_bin_d;
   logic        st_sqrt_q, st_sqrt_d;
   logic        st_dec_q, st_dec_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   function automatic logic bcd_valid(input logic [31:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   always_comb begin
      state_d   = state_q;
      x_cap_d   = x_cap_q;
      prev_d    = prev_q;
      y_d       = y_q;
      err_d     = err_q;
      st_bin_d  = 1'b0;
      st_sqrt_d = 1'b0;
      st_dec_d  = 1'b0;
      done_d    = 1'b0;
      timer_d   = (timer_q == TMR_MAX) ? timer_q : timer_q + 10'd1;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (ce && ((X_in != prev_q) || force_run)) begin
               x_cap_d = X_in;
               prev_d  = X_in;
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            timer_d = '0;
            if (!bcd_valid(x_cap_q)) begin
               err_d   = 2'b01;
               state_d = S_IDLE;
            end else begin
               st_bin_d = 1'b1;
               state_d  = S_BIN;
            end
         end
         // An ok arriving on the very cycle the timer reaches TMO still wins.
         S_BIN: begin
            if (ok_bin) begin
               st_sqrt_d = 1'b1;
               timer_d   = '0;
               state_d   = S_SQRT;
            end else if (timer_q >= TMO_V) begin
               err_d   = 2'b10;
               state_d = S_IDLE;
            end
         end
         S_SQRT: begin
            if (ok_sqrt) begin
               st_dec_d = 1'b1;
               timer_d  = '0;
               state_d  = S_DEC;
            end else if (timer_q >= TMO_V) begin
               err_d   = 2'b11;
               state_d = S_IDLE;
            end
         end
         S_DEC: begin
            if (timer_q >= DEC_LAST) state_d = S_FIN;
         end
         S_FIN: begin
            y_d     = dec_in;
            done_d  = 1'b1;
            err_d   = 2'b00;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         x_cap_q   <= '0;
         prev_q    <= '0;
         y_q       <= '0;
         err_q     <= 2'b00;
         st_bin_q  <= 1'b0;
         st_sqrt_q <= 1'b0;
         st_dec_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         x_cap_q   <= x_cap_d;
         prev_q    <= prev_d;
         y_q       <= y_d;
         err_q     <= err_d;
         st_bin_q  <= st_bin_d;
         st_sqrt_q <= st_sqrt_d;
         st_dec_q  <= st_dec_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign X_cap   = x_cap_q;
   assign st_bin  = st_bin_q;
   assign st_sqrt = st_sqrt_q;
   assign st_dec  = st_dec_q;
   assign Y       = y_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_sqrt_chain_seq.sv
// Bench for sqrt_chain_seq: stage models answer the start pulses, a scoreboard checks every done.
module tb_sqrt_chain_seq;
   localparam int DEC_CYC = 40;

   logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, force_run = 1'b0;
   logic        ok_bin = 1'b0, ok_sqrt = 1'b0;
   logic [31:0] X_in = '0, dec_in = '0;
   logic [31:0] X_cap, Y;
   logic        st_bin, st_sqrt, st_dec, busy, done;
   logic [1:0]  err;

   sqrt_chain_seq #(.TMO(1023), .DEC_CYC(DEC_CYC)) dut (
      .clk(clk), .rst(rst), .ce(ce), .force_run(force_run), .X_in(X_in), .X_cap(X_cap),
      .st_bin(st_bin), .ok_bin(ok_bin), .st_sqrt(st_sqrt), .ok_sqrt(ok_sqrt), .st_dec(st_dec),
      .dec_in(dec_in), .Y(Y), .busy(busy), .done(done), .err(err)
   );

   int tests = 0, fails = 0, cyc = 0;
   int bin_dly = 30, sqrt_dly = 20;
   logic [31:0] dec_res = 32'h12;
   int ce_cyc, stb_cyc, sts_cyc, std_cyc, okb_cyc, oks_cyc, done_cyc, busy_fall_cyc;
   int n_stb = 0, n_sts = 0, n_std = 0, n_done = 0, overlap = 0;
   logic [33:0] sb_q[$];
   logic busy_prev = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor and scoreboard
   always @(negedge clk) begin
      logic [33:0] e;
      if (st_bin)  begin n_stb++; stb_cyc = cyc; end
      if (st_sqrt) begin n_sts++; sts_cyc = cyc; end
      if (st_dec)  begin n_std++; std_cyc = cyc; end
      if ((st_bin && st_sqrt) || (st_bin && st_dec) || (st_sqrt && st_dec)) overlap++;
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;
      if (done) begin
         n_done++;
         done_cyc = cyc;
         if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: Y=0x%0h with empty scoreboard", Y);
         end else begin
            e = sb_q.pop_front();
            check("done_Y", Y, e[33:2]);
            check("done_err", 32'(err), 32'(e[1:0]));
         end
      end
   end

   // Stage models
   always @(negedge clk) begin
      if (st_bin) begin
         repeat (bin_dly) @(negedge clk);
         okb_cyc = cyc; ok_bin = 1'b1;
         @(negedge clk); ok_bin = 1'b0;
      end
   end
   always @(negedge clk) begin
      if (st_sqrt && sqrt_dly >= 0) begin
         repeat (sqrt_dly) @(negedge clk);
         oks_cyc = cyc; ok_sqrt = 1'b1;
         @(negedge clk); ok_sqrt = 1'b0;
      end
   end
   always @(negedge clk) begin
      if (st_dec) begin
         dec_in = 32'hDEAD_BEEF;
         repeat (DEC_CYC) @(negedge clk);
         dec_in = dec_res;
      end
   end

   task automatic clr;
      n_stb = 0; n_sts = 0; n_std = 0; n_done = 0;
   endtask

   task automatic run_ce(input logic [31:0] x);
      @(negedge clk);
      X_in = x; ce_cyc = cyc; ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (busy && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_Y", Y, 32'h0);
      check("rst_Xcap", X_cap, 32'h0);
      check("rst_busy_done", {30'd0, busy, done}, 32'd0);
      check("rst_st", {29'd0, st_bin, st_sqrt, st_dec}, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: nominal run
      clr(); bin_dly = 30; sqrt_dly = 20; dec_res = 32'h12;
      sb_q.push_back({32'h12, 2'b00});
      run_ce(32'h0000_0144);
      wait_idle("t1_idle", 500);
      check("t1_ce_to_stbin", 32'(stb_cyc - ce_cyc), 32'd2);
      check("t1_okb_to_stsqrt", 32'(sts_cyc - okb_cyc), 32'd1);
      check("t1_oks_to_stdec", 32'(std_cyc - oks_cyc), 32'd1);
      check("t1_stdec_to_done", 32'(done_cyc - std_cyc), 32'(DEC_CYC + 1));
      check("t1_pulses", {n_stb[7:0], n_sts[7:0], n_std[7:0], n_done[7:0]}, 32'h0101_0101);
      check("t1_Xcap", X_cap, 32'h144);

      // 2: unchanged operand without force, then with force
      clr();
      run_ce(32'h0000_0144);
      check("t2_noforce_busy", 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      check("t2_noforce_stbin", 32'(n_stb), 32'd0);
      force_run = 1'b1;
      sb_q.push_back({32'h12, 2'b00});
      run_ce(32'h0000_0144);
      force_run = 1'b0;
      wait_idle("t2_idle", 500);
      check("t2_force_done", 32'(n_done), 32'd1);

      // 3: invalid BCD digit
      clr();
      run_ce(32'h0000_01A4);
      check("t3_busy_chk", 32'(busy), 32'd1);
      @(negedge clk);
      check("t3_busy_after", 32'(busy), 32'd0);
      check("t3_err", 32'(err), 32'd1);
      repeat (3) @(negedge clk);
      check("t3_Y_kept", Y, 32'h12);
      check("t3_no_stbin", 32'(n_stb), 32'd0);

      // 4: sqrt timeout, then recovery
      clr(); bin_dly = 5; sqrt_dly = -1;
      run_ce(32'h0000_0169);
      wait_idle("t4_idle", 1500);
      check("t4_tmo_cycles", 32'(busy_fall_cyc - sts_cyc), 32'd1024);
      check("t4_err", 32'(err), 32'd3);
      check("t4_Y_kept", Y, 32'h12);
      check("t4_no_stdec", 32'(n_std), 32'd0);
      clr(); sqrt_dly = 3; dec_res = 32'h14;
      sb_q.push_back({32'h14, 2'b00});
      run_ce(32'h0000_0196);
      wait_idle("t4b_idle", 500);
      check("t4b_err_clear", 32'(err), 32'd0);

      // 5: ok_bin on the last allowed cycle, then spurious ok_sqrt while idle
      clr(); bin_dly = 1023; sqrt_dly = 2; dec_res = 32'h15;
      sb_q.push_back({32'h15, 2'b00});
      run_ce(32'h0000_0225);
      wait_idle("t5_idle", 1500);
      check("t5_sqrt_started", 32'(n_sts), 32'd1);
      check("t5_err", 32'(err), 32'd0);
      clr();
      @(negedge clk); ok_sqrt = 1'b1;
      @(negedge clk); ok_sqrt = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_spurious_busy", 32'(busy), 32'd0);
      check("t5_spurious_st", 32'(n_std + n_done), 32'd0);
      check("t5_spurious_Y", Y, 32'h15);

      // 6: reset in the middle of SQRT
      clr(); bin_dly = 3; sqrt_dly = -1;
      run_ce(32'h0000_0144);
      for (int n = 0; n < 100 && n_sts == 0; n++) @(negedge clk);
      check("t6_reached_sqrt", 32'(n_sts), 32'd1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_rst_Y", Y, 32'h0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_st", {29'd0, st_bin, st_sqrt, st_dec}, 32'd0);
      @(negedge clk); rst = 1'b0;
      clr(); sqrt_dly = 4; dec_res = 32'h12;
      sb_q.push_back({32'h12, 2'b00});
      run_ce(32'h0000_0144);
      wait_idle("t6_idle", 500);
      check("t6_rerun_Y", Y, 32'h12);
      check("t6_rerun_done", 32'(n_done), 32'd1);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      check("no_st_overlap", 32'(overlap), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
